// File: rtl/display_sched_pkg.sv
// -----------------------------------------------------------------------------
// display_sched_pkg
//   Shared types and helpers for the display page scheduler:
//   - sched_state_t  : rotation state (AUTO rotates pages, HOLD freezes them)
//   - calc_dwell_cyc : converts a dwell time in ms into clock cycles
// -----------------------------------------------------------------------------
package display_sched_pkg;

  typedef enum logic {
    AUTO = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

  // Dwell length in clock cycles: dwell_ms * 1e6 / clk_per_ns, never below 1
  // so a degenerate configuration still rotates once per cycle.
  function automatic int unsigned calc_dwell_cyc(input int unsigned dwell_ms,
                                                 input int unsigned clk_per);
    longint unsigned cyc;
    if (clk_per == 0) return 1;
    cyc = (64'(dwell_ms) * 64'd1_000_000) / 64'(clk_per);
    if (cyc < 64'd1) cyc = 64'd1;
    return 32'(cyc);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
//   Free-running dwell counter 0..DWELL_CYC-1 used for page auto-rotation.
//
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, forces count to 0
//   clear  : synchronous clear, forces count to 0 at the next edge
//   enable : count while high
//   expire : high during the last dwell cycle (count == DWELL_CYC-1) while
//            enabled; the consumer acts on it at the coming edge
// -----------------------------------------------------------------------------
module dwell_timer #(
  parameter int unsigned DWELL_CYC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYC - 1);

  logic [CNT_W-1:0] count;

  // Combinational so the page advances on the very edge that ends the dwell,
  // giving exactly DWELL_CYC cycles per page.
  assign expire = enable && (count == LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/display_page_scheduler.sv
// -----------------------------------------------------------------------------
// display_page_scheduler
//   Multiplexes NUM_SRC multi-digit counter sources onto one seven-segment
//   display. Pages rotate automatically every DWELL_MS (AUTO) or only on a
//   button press (HOLD).
//
//   Parameters
//     NUM_SRC      : number of sources, 2..16
//     NUM_SEGMENTS : digits per source / per output
//     CLK_PER      : clock period in ns
//     DWELL_MS     : auto-rotate dwell per page in ms
//
//   Ports
//     clk             : clock, rising edge
//     reset           : synchronous active-high reset
//     src_encoded     : per-source digit nibbles
//     src_digit_point : per-source digit points
//     btn_next        : one-cycle pulse, advance to next page
//     btn_hold        : one-cycle pulse, toggle AUTO <-> HOLD
//     encoded         : registered digits of the displayed source
//     digit_point     : registered digit points of the displayed source
//     page            : index of the displayed source
//     page_changed    : one-cycle pulse on the first cycle of a new page
//     holding         : high while in HOLD
//
//   Build option
//     DISPLAY_PAGE_INDICATOR_EN : when defined, the digit point at position
//       (page mod NUM_SEGMENTS) is forced on to show which page is displayed.
// -----------------------------------------------------------------------------
module display_page_scheduler
  import display_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned NUM_SEGMENTS = 4,
  parameter int unsigned CLK_PER      = 10,
  parameter int unsigned DWELL_MS     = 2000
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_SRC-1:0][NUM_SEGMENTS-1:0][3:0] src_encoded,
  input  logic [NUM_SRC-1:0][NUM_SEGMENTS-1:0]      src_digit_point,
  input  logic                                      btn_next,
  input  logic                                      btn_hold,
  output logic [NUM_SEGMENTS-1:0][3:0]              encoded,
  output logic [NUM_SEGMENTS-1:0]                   digit_point,
  output logic [$clog2(NUM_SRC)-1:0]                page,
  output logic                                      page_changed,
  output logic                                      holding
);

  localparam int unsigned DWELL_CYC = calc_dwell_cyc(DWELL_MS, CLK_PER);
  localparam int unsigned PAGE_W    = $clog2(NUM_SRC);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_SRC - 1);

  sched_state_t              state;
  sched_state_t              next_state;
  logic                      dwell_clear;
  logic                      expire;
  logic                      advance;
  logic [PAGE_W-1:0]         next_page;
  logic [NUM_SEGMENTS-1:0]   page_mark;

  // The dwell restarts on a manual advance and on any state toggle, and is
  // pinned at 0 for as long as rotation is held.
  assign dwell_clear = btn_next || btn_hold || (state == HOLD);

  dwell_timer #(
    .DWELL_CYC (DWELL_CYC)
  ) u_dwell_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (dwell_clear),
    .enable (state == AUTO),
    .expire (expire)
  );

  // A button press landing on the expiry cycle merges into a single advance.
  assign advance   = btn_next || expire;
  assign next_page = (page == LAST_PAGE) ? '0 : page + 1'b1;

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (btn_hold) next_state = (state == AUTO) ? HOLD : AUTO;
  end

`ifdef DISPLAY_PAGE_INDICATOR_EN
  always_comb begin
    page_mark = '0;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      page_mark[i] = ((int'(page) % NUM_SEGMENTS) == i);
    end
  end
`else
  assign page_mark = '0;
`endif

  // Scheduler FSM with registered outputs. encoded/digit_point sample the
  // current page, so they follow a page or source change one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= AUTO;
      page         <= '0;
      page_changed <= 1'b0;
      holding      <= 1'b0;
      encoded      <= '0;
      digit_point  <= '0;
    end else begin
      state        <= next_state;
      holding      <= (next_state == HOLD);
      page_changed <= advance;
      if (advance) page <= next_page;
      encoded      <= src_encoded[page];
      digit_point  <= src_digit_point[page] | page_mark;
    end
  end

endmodule

// File: tb/tb_display_page_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_page_scheduler
//   Directed bench: NUM_SRC=3, NUM_SEGMENTS=4, CLK_PER=1_000_000, DWELL_MS=4,
//   giving a 4-cycle dwell. Inputs are driven and outputs sampled 1 ns after
//   each rising edge.
// -----------------------------------------------------------------------------
module tb_display_page_scheduler;

  localparam int NUM_SRC = 3;
  localparam int NUM_SEG = 4;

  logic                               clk = 1'b0;
  logic                               reset;
  logic [NUM_SRC-1:0][NUM_SEG-1:0][3:0] src_encoded;
  logic [NUM_SRC-1:0][NUM_SEG-1:0]    src_digit_point;
  logic                               btn_next;
  logic                               btn_hold;
  logic [NUM_SEG-1:0][3:0]            encoded;
  logic [NUM_SEG-1:0]                 digit_point;
  logic [1:0]                         page;
  logic                               page_changed;
  logic                               holding;

  logic [15:0] src_val [NUM_SRC];
  logic [3:0]  dp_val  [NUM_SRC];

  int checks = 0;
  int errors = 0;

  assign src_encoded     = {src_val[2], src_val[1], src_val[0]};
  assign src_digit_point = {dp_val[2], dp_val[1], dp_val[0]};

  always #5 clk = ~clk;

  display_page_scheduler #(
    .NUM_SRC      (NUM_SRC),
    .NUM_SEGMENTS (NUM_SEG),
    .CLK_PER      (1_000_000),
    .DWELL_MS     (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .src_encoded     (src_encoded),
    .src_digit_point (src_digit_point),
    .btn_next        (btn_next),
    .btn_hold        (btn_hold),
    .encoded         (encoded),
    .digit_point     (digit_point),
    .page            (page),
    .page_changed    (page_changed),
    .holding         (holding)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_dp(input int p);
    logic [3:0] v;
    v = dp_val[p];
`ifdef DISPLAY_PAGE_INDICATOR_EN
    v[p % NUM_SEG] = 1'b1;
`endif
    return v;
  endfunction

  initial begin
    int cur;
    reset    = 1'b1;
    btn_next = 1'b0;
    btn_hold = 1'b0;
    src_val[0] = 16'h1111; src_val[1] = 16'h2222; src_val[2] = 16'h3333;
    dp_val[0]  = 4'b1000;  dp_val[1]  = 4'b1010;  dp_val[2]  = 4'b0000;

    // Reset state
    tick(); tick();
    check("rst_page",    32'(page), 0);
    check("rst_holding", 32'(holding), 0);
    check("rst_pchg",    32'(page_changed), 0);
    check("rst_enc",     32'(encoded), 0);
    check("rst_dp",      32'(digit_point), 0);
    reset = 1'b0;

    // Auto rotation 0->1->2->0, one step every 4 cycles
    cur = 0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("auto_enc", 32'(encoded), 32'(src_val[cur]));
      check("auto_dp",  32'(digit_point), 32'(exp_dp(cur)));
      tick(); tick();
      check("auto_hold_page", 32'(page), 32'(cur));
      check("auto_pchg_lo",   32'(page_changed), 0);
      tick();
      cur = (cur + 1) % NUM_SRC;
      check("auto_step_page", 32'(page), 32'(cur));
      check("auto_pchg_hi",   32'(page_changed), 1);
    end

    // Hold: page frozen for 20 cycles, btn_next still advances
    btn_hold = 1'b1; tick(); btn_hold = 1'b0;
    check("hold_on", 32'(holding), 1);
    repeat (20) tick();
    check("hold_page",  32'(page), 0);
    check("hold_pchg",  32'(page_changed), 0);
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    check("hold_next_page", 32'(page), 1);
    check("hold_next_pchg", 32'(page_changed), 1);
    tick();
    check("hold_next_pchg_once", 32'(page_changed), 0);
    check("hold_still", 32'(holding), 1);

    // Source change on the displayed page shows one cycle later
    src_val[1] = 16'h1234;
    tick();
    check("src_enc_1234", 32'(encoded), 32'h1234);

    // Back to AUTO; btn_next on the expiry cycle advances only once
    btn_hold = 1'b1; tick(); btn_hold = 1'b0;
    check("auto_again", 32'(holding), 0);
    tick(); tick(); tick();
    check("pre_expiry_page", 32'(page), 1);
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    check("coinc_page", 32'(page), 2);
    check("coinc_pchg", 32'(page_changed), 1);
    tick(); tick(); tick();
    check("coinc_dwell_page", 32'(page), 2);
    check("coinc_dwell_pchg", 32'(page_changed), 0);
    tick();
    check("coinc_next_auto", 32'(page), 0);

    // Hold + next together: state toggles and page advances
    btn_next = 1'b1; btn_hold = 1'b1; tick(); btn_hold = 1'b0;
    check("both_page", 32'(page), 1);
    check("both_hold", 32'(holding), 1);
    tick(); btn_next = 1'b0;
    check("hold_p2", 32'(page), 2);
    tick();
    check("p2_enc", 32'(encoded), 32'(src_val[2]));
    check("p2_dp",  32'(digit_point), 32'(exp_dp(2)));
`ifdef DISPLAY_PAGE_INDICATOR_EN
    check("p2_dp_const", 32'(digit_point), 32'b0100);
`else
    check("p2_dp_const", 32'(digit_point), 32'b0000);
`endif

    // Reset wins over buttons, at page 2 in HOLD
    reset = 1'b1; btn_next = 1'b1; btn_hold = 1'b1;
    tick();
    reset = 1'b0; btn_next = 1'b0; btn_hold = 1'b0;
    check("mid_rst_page", 32'(page), 0);
    check("mid_rst_hold", 32'(holding), 0);
    check("mid_rst_enc",  32'(encoded), 0);
    check("mid_rst_dp",   32'(digit_point), 0);
    check("mid_rst_pchg", 32'(page_changed), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
